// File: rtl/amt_repair_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : amt_repair_ctrl
// Description : Copies the architectural map table (AMT) into the speculative
//               rename map table (RMT) after a pipeline recovery, moving
//               N_PACKETS entries per cycle. Rename and commit are held off
//               through repairFlag_o until the last RMT write has been issued.
//
// Ports
//   clk            : clock, all state changes on the rising edge
//   reset          : synchronous, active-high reset
//   recoverFlag_i  : one-cycle request to (re)start a repair
//   repairFlag_o   : repair in progress (AMT read-port mux select / stall)
//   repairAddr_o   : AMT repair read addresses, one per lane
//   repairData_i   : AMT repair read data, combinational from repairAddr_o
//   rmtWrAddr_o    : RMT write addresses, one per lane
//   rmtWrData_o    : RMT write data, one per lane
//   rmtWe_o        : per-lane RMT write enable
//   repairDone_o   : one-cycle pulse in the cycle of the final RMT write
//
// Revision    : 1.0 - initial release
// ============================================================================
module amt_repair_ctrl #(
    parameter int DEPTH     = 34,
    parameter int INDEX     = 6,
    parameter int WIDTH     = 7,
    parameter int N_PACKETS = 8
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                recoverFlag_i,
    output logic                                repairFlag_o,
    output logic [N_PACKETS-1:0][INDEX-1:0]     repairAddr_o,
    input  logic [N_PACKETS-1:0][WIDTH-1:0]     repairData_i,
    output logic [N_PACKETS-1:0][INDEX-1:0]     rmtWrAddr_o,
    output logic [N_PACKETS-1:0][WIDTH-1:0]     rmtWrData_o,
    output logic [N_PACKETS-1:0]                rmtWe_o,
    output logic                                repairDone_o
);

    // Number of packets needed to cover every logical register.
    localparam int C_NUM_PKT = (DEPTH + N_PACKETS - 1) / N_PACKETS;
    localparam int C_CNT_W   = (C_NUM_PKT > 1) ? $clog2(C_NUM_PKT) : 1;
    // Lane addresses can run past DEPTH in a partial final packet, so they
    // are computed wide enough to hold NUM_PKT*N_PACKETS-1 before the range
    // check.
    localparam int C_LANE_W  = (C_NUM_PKT * N_PACKETS > 1) ?
                               $clog2(C_NUM_PKT * N_PACKETS) : 1;
    localparam logic [C_CNT_W-1:0] C_LAST_PKT = C_CNT_W'(C_NUM_PKT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                          r_state;
    state_t                          w_state_nxt;
    logic [C_CNT_W-1:0]              r_pkt_cnt;
    logic [C_CNT_W-1:0]              w_pkt_cnt_nxt;
    logic [N_PACKETS-1:0][C_LANE_W-1:0] w_lane_addr;
    logic [N_PACKETS-1:0]            w_lane_vld;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_pkt_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pkt_cnt <= w_pkt_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and status outputs. A recovery request in any state
    // restarts the copy from packet 0; a write already captured in the
    // write stage is still committed because it carries valid AMT data.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_pkt_cnt_nxt = r_pkt_cnt;
        repairFlag_o  = 1'b0;
        repairDone_o  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (recoverFlag_i) begin
                    w_state_nxt   = ST_READ;
                    w_pkt_cnt_nxt = '0;
                end
            end

            ST_READ: begin
                repairFlag_o = 1'b1;
                if (recoverFlag_i) begin
                    w_state_nxt   = ST_READ;
                    w_pkt_cnt_nxt = '0;
                end else if (r_pkt_cnt == C_LAST_PKT) begin
                    w_state_nxt   = ST_DRAIN;
                    w_pkt_cnt_nxt = '0;
                end else begin
                    w_pkt_cnt_nxt = r_pkt_cnt + C_CNT_W'(1);
                end
            end

            ST_DRAIN: begin
                repairFlag_o  = 1'b1;
                repairDone_o  = 1'b1;
                w_pkt_cnt_nxt = '0;
                if (recoverFlag_i) begin
                    w_state_nxt = ST_READ;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end

            default: begin
                w_state_nxt   = ST_IDLE;
                w_pkt_cnt_nxt = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Per-lane read address generation and write stage
    // ------------------------------------------------------------------
    generate
        for (genvar i = 0; i < N_PACKETS; i++) begin : g_lane
            assign w_lane_addr[i] = C_LANE_W'(r_pkt_cnt) * C_LANE_W'(N_PACKETS)
                                  + C_LANE_W'(i);
            assign w_lane_vld[i]  = (32'(w_lane_addr[i]) < 32'(DEPTH));

            // Out-of-range lanes read entry 0 so the AMT never sees an
            // address beyond its depth.
            assign repairAddr_o[i] = ((r_state == ST_READ) && w_lane_vld[i]) ?
                                     INDEX'(w_lane_addr[i]) : '0;

            // One-cycle AMT-to-RMT pipeline stage.
            always_ff @(posedge clk) begin
                if (reset) begin
                    rmtWrAddr_o[i] <= '0;
                    rmtWrData_o[i] <= '0;
                    rmtWe_o[i]     <= 1'b0;
                end else if (r_state == ST_READ) begin
                    rmtWrAddr_o[i] <= INDEX'(w_lane_addr[i]);
                    rmtWrData_o[i] <= repairData_i[i];
                    rmtWe_o[i]     <= w_lane_vld[i];
                end else begin
                    rmtWe_o[i]     <= 1'b0;
                end
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_amt_repair_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_amt_repair_ctrl
// Description : Self-checking bench for amt_repair_ctrl. Instance A uses the
//               default 34-entry table, instance B a 32-entry table that
//               divides evenly into packets. The AMT holds entry k = k+40.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_amt_repair_ctrl;

    localparam int DEPTH   = 34;
    localparam int DEPTH_B = 32;
    localparam int INDEX   = 6;
    localparam int WIDTH   = 7;
    localparam int NP      = 8;
    localparam int NUM_PKT = 5;   // ceil(34/8)

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic rec_a;
    logic rec_b;
    logic rmt_clr;
    logic chk_en;

    logic                          a_flag, a_done, b_flag, b_done;
    logic [NP-1:0][INDEX-1:0]      a_addr, a_wa, b_addr, b_wa;
    logic [NP-1:0][WIDTH-1:0]      a_data, a_wd, b_data, b_wd;
    logic [NP-1:0]                 a_we, b_we;

    amt_repair_ctrl #(.DEPTH(DEPTH), .INDEX(INDEX), .WIDTH(WIDTH), .N_PACKETS(NP)) u_dut_a (
        .clk(clk), .reset(reset), .recoverFlag_i(rec_a), .repairFlag_o(a_flag),
        .repairAddr_o(a_addr), .repairData_i(a_data), .rmtWrAddr_o(a_wa),
        .rmtWrData_o(a_wd), .rmtWe_o(a_we), .repairDone_o(a_done)
    );

    amt_repair_ctrl #(.DEPTH(DEPTH_B), .INDEX(INDEX), .WIDTH(WIDTH), .N_PACKETS(NP)) u_dut_b (
        .clk(clk), .reset(reset), .recoverFlag_i(rec_b), .repairFlag_o(b_flag),
        .repairAddr_o(b_addr), .repairData_i(b_data), .rmtWrAddr_o(b_wa),
        .rmtWrData_o(b_wd), .rmtWe_o(b_we), .repairDone_o(b_done)
    );

    // AMT: combinational read, entry k holds k+40.
    always_comb begin
        a_data = '0;
        b_data = '0;
        for (int i = 0; i < NP; i++) begin
            a_data[i] = WIDTH'(a_addr[i]) + 7'd40;
            b_data[i] = WIDTH'(b_addr[i]) + 7'd40;
        end
    end

    // RMT: written at the edge that ends the cycle with rmtWe_o high.
    logic [WIDTH-1:0] a_rmt [64];
    logic [WIDTH-1:0] b_rmt [64];
    always @(posedge clk) begin
        if (rmt_clr) begin
            for (int k = 0; k < 64; k++) begin
                a_rmt[k] <= '0;
                b_rmt[k] <= '0;
            end
        end else begin
            for (int i = 0; i < NP; i++) begin
                if (a_we[i]) a_rmt[a_wa[i]] <= a_wd[i];
                if (b_we[i]) b_rmt[b_wa[i]] <= b_wd[i];
            end
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model of instance A: a pass that started at the edge
    // ending cycle m_start reads packet (t - m_start - 1) in cycle t, the
    // packet read in one cycle is written in the next, and the done pulse
    // falls in the cycle after the last packet read.
    // ------------------------------------------------------------------
    int m_cyc     = 0;
    int m_start   = 0;
    bit m_act     = 1'b0;
    int m_prev_rd = -1;

    function automatic int rd_pkt(input int cyc, input int st, input bit act);
        int k;
        k = cyc - st - 1;
        if (act && k >= 0 && k < NUM_PKT) return k;
        return -1;
    endfunction

    always @(posedge clk) begin
        m_cyc <= m_cyc + 1;
        if (reset) begin
            m_act     <= 1'b0;
            m_prev_rd <= -1;
        end else begin
            m_prev_rd <= rd_pkt(m_cyc, m_start, m_act);
            if (rec_a) begin
                m_act   <= 1'b1;
                m_start <= m_cyc;
            end
        end
    end

    // Compare process, every cycle once reset has settled.
    always @(negedge clk) begin
        int k;
        int rd;
        int a;
        logic [NP-1:0][INDEX-1:0] ea, ewa, awa;
        logic [NP-1:0][WIDTH-1:0] ewd, awd;
        logic [NP-1:0]            ewe;
        if (chk_en) begin
            k  = m_act ? (m_cyc - m_start - 1) : -1;
            rd = (k >= 0 && k < NUM_PKT) ? k : -1;
            ea = '0; ewa = '0; ewd = '0; ewe = '0; awa = '0; awd = '0;
            for (int i = 0; i < NP; i++) begin
                a = rd * NP + i;
                if (rd >= 0 && a < DEPTH) ea[i] = INDEX'(a);
                a = m_prev_rd * NP + i;
                if (m_prev_rd >= 0 && a < DEPTH) begin
                    ewe[i] = 1'b1;
                    ewa[i] = INDEX'(a);
                    ewd[i] = WIDTH'(a + 40);
                end
                if (a_we[i]) begin
                    awa[i] = a_wa[i];
                    awd[i] = a_wd[i];
                end
            end
            chk("model_flag",  64'(a_flag), 64'(k >= 0 && k <= NUM_PKT));
            chk("model_done",  64'(a_done), 64'(k == NUM_PKT));
            chk("model_raddr", 64'(a_addr), 64'(ea));
            chk("model_we",    64'(a_we),   64'(ewe));
            chk("model_waddr", 64'(awa),    64'(ewa));
            chk("model_wdata", 64'(awd),    64'(ewd));
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clear_rmt();
        rmt_clr = 1'b1;
        tick();
        rmt_clr = 1'b0;
    endtask

    task automatic check_rmt_a();
        for (int k = 0; k < DEPTH; k++) chk("rmt_a_entry", 64'(a_rmt[k]), 64'(k + 40));
    endtask

    logic [NP-1:0][INDEX-1:0] v_pkt0, v_pkt2, v_last_a, v_last_b;

    initial begin
        v_pkt0   = {6'd7, 6'd6, 6'd5, 6'd4, 6'd3, 6'd2, 6'd1, 6'd0};
        v_pkt2   = {6'd23, 6'd22, 6'd21, 6'd20, 6'd19, 6'd18, 6'd17, 6'd16};
        v_last_a = {6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd33, 6'd32};
        v_last_b = {6'd31, 6'd30, 6'd29, 6'd28, 6'd27, 6'd26, 6'd25, 6'd24};
        reset = 1'b1; rec_a = 1'b0; rec_b = 1'b0; rmt_clr = 1'b1; chk_en = 1'b0;
        repeat (3) tick();
        chk_en  = 1'b1;
        reset   = 1'b0;
        rmt_clr = 1'b0;

        // Reset values, then idle for 10 cycles.
        chk("rst_addr",  64'(a_addr), 64'd0);
        chk("rst_waddr", 64'(a_wa),   64'd0);
        chk("rst_wdata", 64'(a_wd),   64'd0);
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("idle_flag", 64'(a_flag | b_flag), 64'd0);
            chk("idle_we",   64'(a_we | b_we),     64'd0);
            chk("idle_done", 64'(a_done | b_done), 64'd0);
        end

        // Full repair of 34 entries.
        clear_rmt();
        rec_a = 1'b1; tick(); rec_a = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (c == 1) chk("p_addr_c1",   64'(a_addr), 64'(v_pkt0));
            if (c == 1) chk("p_flag_c1",   64'(a_flag), 64'd1);
            if (c == 2) chk("p_we_c2",     64'(a_we),   64'hFF);
            if (c == 5) chk("p_addr_c5",   64'(a_addr), 64'(v_last_a));
            if (c == 5) chk("p_done_c5",   64'(a_done), 64'd0);
            if (c == 6) chk("p_we_c6",     64'(a_we),   64'h03);
            if (c == 6) chk("p_done_c6",   64'(a_done), 64'd1);
            if (c == 7) chk("p_flag_c7",   64'(a_flag), 64'd0);
            tick();
        end
        check_rmt_a();

        // Evenly divisible table: 4 packets, full final packet.
        rec_b = 1'b1; tick(); rec_b = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            if (c == 1) chk("b_addr_c1",  64'(b_addr), 64'(v_pkt0));
            if (c == 4) chk("b_done_c4",  64'(b_done), 64'd0);
            if (c == 5) chk("b_we_c5",    64'(b_we),   64'hFF);
            if (c == 5) chk("b_waddr_c5", 64'(b_wa),   64'(v_last_b));
            if (c == 5) chk("b_done_c5",  64'(b_done), 64'd1);
            if (c == 6) chk("b_flag_c6",  64'(b_flag), 64'd0);
            tick();
        end
        for (int k = 0; k < DEPTH_B; k++) chk("rmt_b_entry", 64'(b_rmt[k]), 64'(k + 40));

        // Restart in cycle 3.
        clear_rmt();
        rec_a = 1'b1; tick(); rec_a = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            if (c == 3) rec_a = 1'b1;
            if (c == 4) begin
                rec_a = 1'b0;
                chk("rs_we_c4",    64'(a_we),   64'hFF);
                chk("rs_waddr_c4", 64'(a_wa),   64'(v_pkt2));
                chk("rs_addr_c4",  64'(a_addr), 64'(v_pkt0));
            end
            if (c == 6)  chk("rs_done_c6",  64'(a_done), 64'd0);
            if (c == 8)  chk("rs_done_c8",  64'(a_done), 64'd0);
            if (c == 9)  chk("rs_done_c9",  64'(a_done), 64'd1);
            if (c == 10) chk("rs_flag_c10", 64'(a_flag), 64'd0);
            tick();
        end
        check_rmt_a();

        // Reset asserted in cycle 3 of a repair.
        rec_a = 1'b1; tick(); rec_a = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            if (c == 3) reset = 1'b1;
            if (c == 4) begin
                reset = 1'b0;
                chk("rr_flag",  64'(a_flag), 64'd0);
                chk("rr_done",  64'(a_done), 64'd0);
                chk("rr_we",    64'(a_we),   64'd0);
                chk("rr_addr",  64'(a_addr), 64'd0);
                chk("rr_waddr", 64'(a_wa),   64'd0);
                chk("rr_wdata", 64'(a_wd),   64'd0);
            end
            if (c > 4) chk("rr_nodone", 64'(a_done), 64'd0);
            tick();
        end

        // Back-to-back passes.
        clear_rmt();
        rec_a = 1'b1; tick(); rec_a = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            if (c == 7) rec_a = 1'b1;
            if (c == 8) rec_a = 1'b0;
            if (c == 6)  chk("bb_done_c6",  64'(a_done), 64'd1);
            if (c == 7)  chk("bb_flag_c7",  64'(a_flag), 64'd0);
            if (c == 8)  chk("bb_addr_c8",  64'(a_addr), 64'(v_pkt0));
            if (c == 12) chk("bb_done_c12", 64'(a_done), 64'd0);
            if (c == 13) chk("bb_done_c13", 64'(a_done), 64'd1);
            if (c == 14) chk("bb_flag_c14", 64'(a_flag), 64'd0);
            tick();
        end
        check_rmt_a();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
